elastic_reg_pipe: RTL and testbench
===================================

// Module: elastic_reg_pipe
// PURPOSE
//  Parametrised successor to the single-bit synchronous-reset D register.
//  A DEPTH-stage, WIDTH-bit register pipeline with per-stage valid bits,
//  valid/ready backpressure, bubble collapsing and synchronous flush.
//  Retimes datapath buses between the arithmetic and control blocks without losing data under stall.
// PARAMETERS
//  WIDTH  8  data bits per stage (>=1)
//  DEPTH  3  register stages (>=1); latency when unstalled
//  CNT_W  $clog2(DEPTH+1)  occupancy counter width (derived, localparam)
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      reset, synchronous, active-high
//  flush      in   1      synchronous clear of all stage valids
//  in_valid   in   1      upstream data valid
//  in_data    in   WIDTH  upstream data
//  in_ready   out  1      pipe accepts in_data this cycle
//  out_valid  out  1      last stage holds valid data
//  out_data   out  WIDTH  last stage data
//  out_ready  in   1      downstream accepts out_data this cycle
//  occupancy  out  CNT_W  number of valid stages (0..DEPTH)
// BEHAVIOUR
//  Reset: clk is the only clock; reset rst, synchronous, active-high; on rst all v[i]<=0, d[i]<=0.
//   Hence out_valid=0, out_data=0, occupancy=0, in_ready=0 while rst=1; in_ready=1 the cycle after.
//  Stage i (0=input, DEPTH-1=output) holds v[i], d[i].
//  rdy[DEPTH-1] = !v[DEPTH-1] | out_ready; rdy[i] = !v[i] | rdy[i+1].
//   Ready chain is combinational (bubble collapsing); in_ready = rdy[0] & !flush & !rst.
//  Per clock, when rdy[i]: stage i loads from stage i-1 (stage 0 from in_valid/in_data):
//   v[i] <= v[i-1]; d[i] <= d[i-1] only when v[i-1]=1 (data held otherwise, saves toggles).
//   Stage 0 uses v_in = in_valid & in_ready in place of v[i-1].
//  When !rdy[i]: stage i holds v[i], d[i].
//  Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  Latency: DEPTH cycles from input transfer to out_valid with out_ready held 1.
//  Throughput: 1 word/cycle sustained; no bubble inserted on stall release.
//  Full (all v=1, out_ready=0): in_ready=0, all stages hold; no data lost or duplicated.
//  Full with out_ready=1: simultaneous in and out transfer; occupancy unchanged.
//  Empty: out_valid=0; out_data holds last delivered value (not cleared).
//  flush=1: all v[i]<=0 next cycle; d[i] unchanged; in_ready=0 so the same-cycle input is
//   refused (no transfer); the same-cycle output transfer still counts if out_ready=1.
//  Priority: rst > flush > normal shift.
//  Reset or flush mid-stream discards all in-flight words; no partial state survives.
//  occupancy = popcount(v), combinational from registers (no extra latency).
//  Ordering: words exit in strict arrival order; out_data stable while out_valid & !out_ready.
// STRUCTURE
//  Shared package: none needed; CNT_W is a local derived constant.
//  Sub-module erp_stage (WIDTH): one valid+data register with load enable, sync rst/flush.
//   Instantiated DEPTH times in a generate loop; top holds ready chain and popcount.
// TESTING
//  1 rst 3 cycles, release -> out_valid=0, out_data=0, occupancy=0, in_ready=1.
//  2 DEPTH=3, out_ready=1, feed 0x11,0x22,0x33 back-to-back -> 0x11 at out on cycle 3, then 1/cycle.
//  3 out_ready=0, push 4 words -> first 3 accepted, in_ready=0 on 4th, occupancy=3;
//    out_ready=1 -> 0x11,0x22,0x33,0x44 delivered, no gaps, no duplicates.
//  4 full, out_ready=1, in_valid=1 continuous -> occupancy stays 3, one in and one out per cycle.
//  5 occupancy=2, flush=1 with in_valid=1 (0xAA) -> next cycle occupancy=0, 0xAA never emerges.
//  6 rst asserted with occupancy=3 and out_ready=0 -> next cycle out_valid=0, out_data=0.

Source files
------------

// File: rtl/erp_stage.sv
// One valid+data register of the elastic pipe. Data only toggles when a valid word is
// loaded, so empty bubbles moving through the pipe leave the data flops quiet.
module erp_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             load,
   input  logic             v_in,
   input  logic [WIDTH-1:0] d_in,
   output logic             v,
   output logic [WIDTH-1:0] d
);

   always_ff @(posedge clk) begin
      if (rst) begin
         v <= 1'b0;
         d <= '0;
      end else if (flush) begin
         v <= 1'b0;
      end else if (load) begin
         v <= v_in;
         if (v_in) d <= d_in;
      end
   end

endmodule

// File: rtl/elastic_reg_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, synchronous flush
// and an occupancy count of valid stages.
module elastic_reg_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] occupancy
);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d [DEPTH];
   logic [DEPTH-1:0] rdy;

   // A stage may load whenever some stage at or downstream of it is empty, or the
   // output is draining; written without self-reference so the chain stays acyclic.
   always_comb begin
      logic tail_full;
      rdy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         tail_full = 1'b1;
         for (int j = i; j < DEPTH; j++) tail_full = tail_full & v[j];
         rdy[i] = !tail_full | out_ready;
      end
   end

   assign in_ready = rdy[0] & !flush & !rst;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             vi;
      logic [WIDTH-1:0] di;
      if (i == 0) begin : g_first
         assign vi = in_valid & in_ready;
         assign di = in_data;
      end else begin : g_next
         assign vi = v[i-1];
         assign di = d[i-1];
      end
      erp_stage #(.WIDTH(WIDTH)) u_stage (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .load  (rdy[i]),
         .v_in  (vi),
         .d_in  (di),
         .v     (v[i]),
         .d     (d[i])
      );
   end

   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) occupancy = occupancy + CNT_W'(v[i]);
   end

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// Randomized and directed bench for elastic_reg_pipe against a word-list reference model.
module tb_elastic_reg_pipe;
   localparam int WIDTH = 8;
   localparam int DEPTH = 3;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] in_data, out_data;
   logic [CNT_W-1:0] occupancy;

   elastic_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   // Each word in flight with its stage position (0 = input, DEPTH-1 = output).
   typedef struct {
      logic [WIDTH-1:0] data;
      int               pos;
   } word_t;

   word_t            q[$];
   logic [WIDTH-1:0] last_out;
   int               total = 0;
   int               bad   = 0;
   int               aa_seen = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, check DUT against the model, then advance the model
   // to the state the coming posedge produces.
   task automatic cycle(input logic r, input logic f, input logic iv, input logic [WIDTH-1:0] id,
                        input logic ordy, input logic chk);
      logic exp_ir, exp_ov, acc;
      int   lim;
      @(negedge clk);
      rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
      #1;
      exp_ir = !r && !f && (q.size() < DEPTH || ordy);
      exp_ov = q.size() > 0 && q[0].pos == DEPTH - 1;
      if (chk) begin
         check("in_ready", 32'(in_ready), 32'(exp_ir));
         check("out_valid", 32'(out_valid), 32'(exp_ov));
         check("out_data", 32'(out_data), 32'(last_out));
         check("occupancy", 32'(occupancy), 32'(q.size()));
      end
      if (out_valid && ordy && out_data == 8'hAA) aa_seen++;
      acc = iv && exp_ir;
      if (r) begin
         q.delete();
         last_out = '0;
      end else if (f) begin
         q.delete();
      end else begin
         if (exp_ov && ordy) void'(q.pop_front());
         for (int i = 0; i < q.size(); i++) begin
            lim = (i == 0) ? DEPTH - 1 : q[i-1].pos - 1;
            if (q[i].pos < lim) begin
               q[i].pos = q[i].pos + 1;
               if (q[i].pos == DEPTH - 1) last_out = q[i].data;
            end
         end
         if (acc) begin
            q.push_back('{data: id, pos: 0});
            if (DEPTH == 1) last_out = id;
         end
      end
   endtask

   initial begin
      logic [WIDTH-1:0] w;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      last_out = '0;

      // Reset for 3 cycles; first cycle unchecked since state is unknown before it.
      cycle(1, 0, 0, 8'h00, 0, 0);
      cycle(1, 0, 0, 8'h00, 0, 1);
      cycle(1, 0, 0, 8'h00, 0, 1);
      cycle(0, 0, 0, 8'h00, 1, 1);

      // Back-to-back flow with out_ready held.
      cycle(0, 0, 1, 8'h11, 1, 1);
      cycle(0, 0, 1, 8'h22, 1, 1);
      cycle(0, 0, 1, 8'h33, 1, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1, 1);

      // Stall: four pushes into a three-deep pipe, then drain.
      cycle(0, 0, 1, 8'h11, 0, 1);
      cycle(0, 0, 1, 8'h22, 0, 1);
      cycle(0, 0, 1, 8'h33, 0, 1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h44, 0, 1);
      check("full_occ", 32'(occupancy), 32'(DEPTH));
      check("full_in_ready", 32'(in_ready), 32'd0);
      cycle(0, 0, 1, 8'h44, 1, 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'h00, 1, 1);

      // Full with simultaneous in/out.
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'(8'h50 + i), 0, 1);
      for (int i = 0; i < 6; i++) begin
         cycle(0, 0, 1, 8'(8'h60 + i), 1, 1);
         check("steady_occ", 32'(occupancy), 32'(DEPTH));
      end
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'h00, 1, 1);

      // Flush with occupancy 2 while 0xAA is offered.
      cycle(0, 0, 1, 8'h71, 0, 1);
      cycle(0, 0, 1, 8'h72, 0, 1);
      cycle(0, 1, 1, 8'hAA, 0, 1);
      cycle(0, 0, 0, 8'h00, 1, 1);
      check("flush_occ", 32'(occupancy), 32'd0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'h00, 1, 1);
      check("aa_never_out", 32'(aa_seen), 32'd0);

      // Reset while full and stalled.
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'(8'h81 + i), 0, 1);
      cycle(1, 0, 0, 8'h00, 0, 1);
      cycle(0, 0, 0, 8'h00, 0, 1);
      check("rst_out_data", 32'(out_data), 32'd0);

      // Randomized traffic with occasional flush and reset.
      for (int n = 0; n < 3000; n++) begin
         w = 8'($urandom);
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
               ($urandom_range(0, 9) < 7), w,
               (n % 200 < 40) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
